// File: rtl/fill_valve_arbiter.sv
// fill_valve_arbiter
//   Round-robin arbiter sharing one water-inlet valve among N_MACH washer
//   controllers. One washer owns the valve at a time. Each hold is capped at
//   MAX_HOLD cycles. Every grant is followed by a GAP-cycle settle interval
//   with the valve closed.
//
// Ports
//   CLK       system clock, rising edge
//   RST_N     asynchronous active-low reset
//   REQ       per-washer fill request (level)
//   DONE      per-washer fill complete (only the owner's bit is sampled)
//   GNT       one-hot grant, registered, zero when the valve is free
//   GRANT_ID  index of current owner; holds last owner when GNT is zero
//   VALVE     valve open, registered, equals |GNT
//   BUSY      high while granting or settling
//   TIMEOUT   one-cycle pulse when a grant is ended only by the hold cap
module fill_valve_arbiter #(
  parameter int unsigned N_MACH   = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned GAP      = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_MACH-1:0] REQ,
  input  logic [N_MACH-1:0] DONE,
  output logic [N_MACH-1:0] GNT,
  output logic [2:0]        GRANT_ID,
  output logic              VALVE,
  output logic              BUSY,
  output logic              TIMEOUT
);

  localparam int unsigned IW = (N_MACH > 1) ? $clog2(N_MACH) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned SW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SETTLE
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] settle_cnt;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;
  logic          own_done;
  logic          own_drop;
  logic          cap;

  // Rotating priority: scan from the washer after the last owner, wrapping,
  // so the previous owner is always considered last.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_MACH; i++) begin
      cand = IW'((32'(last) + i) % N_MACH);
      if (!found && REQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // While granting, 'last' is the current owner.
  always_comb begin
    own_done = DONE[last];
    own_drop = ~REQ[last];
    cap      = (hold_cnt == HW'(MAX_HOLD - 1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      GNT        <= '0;
      VALVE      <= 1'b0;
      BUSY       <= 1'b0;
      TIMEOUT    <= 1'b0;
      GRANT_ID   <= '0;
      hold_cnt   <= '0;
      settle_cnt <= '0;
      last       <= IW'(N_MACH - 1);
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            GNT       <= '0;
            GNT[pick] <= 1'b1;
            VALVE     <= 1'b1;
            BUSY      <= 1'b1;
            GRANT_ID  <= 3'(pick);
            last      <= pick;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (own_done || own_drop || cap) begin
            state      <= SETTLE;
            GNT        <= '0;
            VALVE      <= 1'b0;
            settle_cnt <= '0;
            // DONE or a dropped REQ outrank the cap as the release cause.
            TIMEOUT    <= cap & ~own_done & ~own_drop;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SW'(GAP - 1)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_valve_arbiter.sv
module tb_fill_valve_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int G  = 2;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] DONE = '0;
  logic [N-1:0] GNT;
  logic [2:0]   GRANT_ID;
  logic         VALVE;
  logic         BUSY;
  logic         TIMEOUT;

  fill_valve_arbiter #(.N_MACH(N), .MAX_HOLD(MH), .GAP(G)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DONE(DONE), .GNT(GNT),
    .GRANT_ID(GRANT_ID), .VALVE(VALVE), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = valve free), GNT cycles served so far,
  // closed-valve cycles still owed, rotation pointer, reported id, timeout flag.
  int m_owner, m_held, m_settle, m_last, m_gid;
  bit m_to;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         valve;
    logic         busy;
    logic         to;
    logic [2:0]   id;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_settle = 0; m_last = N - 1; m_gid = 0; m_to = 0;
  endtask

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
    bit by_done, by_drop, by_cap;
    m_to = 0;
    if (m_owner >= 0) begin
      m_held++;
      by_done = d[m_owner];
      by_drop = !r[m_owner];
      by_cap  = (m_held >= MH);
      if (by_done || by_drop || by_cap) begin
        m_to     = by_cap && !by_done && !by_drop;
        m_owner  = -1;
        m_settle = G;
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (r != '0) begin
      for (int i = 1; i <= N; i++) begin
        int w;
        w = (m_last + i) % N;
        if (r[w]) begin
          m_owner = w;
          break;
        end
      end
      m_last = m_owner;
      m_gid  = m_owner;
      m_held = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".gnt"},     32'(GNT),      32'(m_gnt()));
    chk({tag, ".valve"},   32'(VALVE),    32'(m_owner >= 0));
    chk({tag, ".busy"},    32'(BUSY),     32'((m_owner >= 0) || (m_settle > 0)));
    chk({tag, ".timeout"}, 32'(TIMEOUT),  32'(m_to));
    chk({tag, ".id"},      32'(GRANT_ID), 32'(m_gid));
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input string tag);
    REQ  = r;
    DONE = d;
    @(posedge CLK);
    model_edge(r, d);
    #1;
    compare_all(tag);
  endtask

  task automatic apply_reset(input logic [N-1:0] r);
    @(negedge CLK);
    REQ = r;
    DONE = '0;
    RST_N = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    @(posedge CLK);
    #1;
    compare_all("rst_edge");
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] g,
                     input logic v, input logic b, input logic t, input logic [2:0] id);
    vec_t e;
    e.req = r; e.done = d; e.gnt = g; e.valve = v; e.busy = b; e.to = t; e.id = id;
    tbl.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ord[5];
    int n, sc;
    logic [N-1:0] cur, d;

    // Timeout sequence from reset (last = 3, so washer 2 is granted first).
    add(4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 3'd2);
    for (int i = 0; i < MH - 1; i++) add(4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 3'd2);
    add(4'b0100, 4'b0000, 4'b0000, 0, 1, 1, 3'd2);   // cap reached
    add(4'b0100, 4'b0000, 4'b0000, 0, 1, 0, 3'd2);   // settle
    add(4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 3'd2);   // idle
    add(4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 3'd2);   // re-grant
    add(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 3'd2);   // REQ drop release, no timeout
    add(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 3'd2);
    add(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 3'd2);
    add(4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 3'd2);   // DONE without grant

    // Reset with all requests, first grant to washer 0.
    apply_reset(4'b1111);
    step(4'b1111, 4'b0000, "t1");
    chk("t1_first_gnt", 32'(GNT), 32'h1);

    // Table-driven timeout vectors.
    apply_reset(4'b0000);
    for (int i = 0; i < tbl.size(); i++) begin
      REQ  = tbl[i].req;
      DONE = tbl[i].done;
      @(posedge CLK);
      model_edge(tbl[i].req, tbl[i].done);
      #1;
      chk($sformatf("tbl%0d.gnt", i),     32'(GNT),      32'(tbl[i].gnt));
      chk($sformatf("tbl%0d.valve", i),   32'(VALVE),    32'(tbl[i].valve));
      chk($sformatf("tbl%0d.busy", i),    32'(BUSY),     32'(tbl[i].busy));
      chk($sformatf("tbl%0d.timeout", i), 32'(TIMEOUT),  32'(tbl[i].to));
      chk($sformatf("tbl%0d.id", i),      32'(GRANT_ID), 32'(tbl[i].id));
    end

    // Round-robin with DONE after 3 grant cycles.
    apply_reset(4'b1111);
    ord = '{0, 1, 2, 3, 0};
    sc = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (GNT == '0 && n < 12) begin
        step(4'b1111, 4'b0000, "rr_wait");
        if (BUSY && !VALVE) sc++;
        n++;
      end
      chk($sformatf("rr_order%0d", k), 32'(GNT), 32'(1) << ord[k]);
      if (k > 0) begin
        chk($sformatf("rr_settle%0d", k), 32'(sc), 32'(G));
        chk($sformatf("rr_regrant_lat%0d", k), 32'(n), 32'(G + 1));
      end
      step(4'b1111, 4'b0000, "rr_hold");
      step(4'b1111, 4'b0000, "rr_hold");
      step(4'b1111, m_gnt(), "rr_done");
      sc = (BUSY && !VALVE) ? 1 : 0;
    end

    // DONE on the cap cycle: release without TIMEOUT.
    apply_reset(4'b0001);
    step(4'b0001, 4'b0000, "simul_grant");
    for (int i = 0; i < MH - 1; i++) step(4'b0001, 4'b0000, "simul_hold");
    step(4'b0001, 4'b0001, "simul_rel");
    chk("simul_timeout", 32'(TIMEOUT), 32'h0);
    chk("simul_gnt", 32'(GNT), 32'h0);

    // Owner drops REQ at cycle 4; new requests during settle.
    apply_reset(4'b0000);
    step(4'b0100, 4'b0000, "drop_grant");
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, "drop_hold");
    step(4'b0000, 4'b0000, "drop_rel");
    chk("drop_gnt", 32'(GNT), 32'h0);
    step(4'b1010, 4'b0000, "drop_settle");
    step(4'b1010, 4'b0000, "drop_idle");
    step(4'b1010, 4'b0000, "drop_regrant");
    chk("drop_next_gnt", 32'(GNT), 32'h8);
    chk("drop_next_id", 32'(GRANT_ID), 32'd3);

    // Asynchronous reset at grant cycle 5.
    apply_reset(4'b0000);
    step(4'b0110, 4'b0000, "arst_grant");
    for (int i = 0; i < 4; i++) step(4'b0110, 4'b0000, "arst_hold");
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("arst_gnt", 32'(GNT), 32'h0);
    chk("arst_valve", 32'(VALVE), 32'h0);
    chk("arst_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(4'b0110, 4'b0000, "arst_post");
    chk("arst_post_gnt", 32'(GNT), 32'h2);

    // Randomized traffic against the model.
    apply_reset(4'b0000);
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      d = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
        if ($urandom_range(0, 5) == 0) d[b] = 1'b1;
      end
      step(cur, d, "rnd");
      if ($urandom_range(0, 499) == 0) begin
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all("rnd_arst");
        @(negedge CLK);
        RST_N = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
